// File: rtl/micro_core.sv
// micro_core -- tiny load-then-run processor with a unified program/data memory.
//
// A program is streamed in through the load port while the core sits in LOAD.
// A start pulse then runs it from address 0 until a HALT opcode or a fault.
// Instruction word layout: opcode [23:16], field A [15:8], field B [7:0].
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   load_valid/load_data  program word offered while in LOAD
//   load_ready            word can be accepted (LOAD and memory not yet full)
//   start                 one-cycle pulse; accepted in LOAD, HALT or FAULT
//   busy/halted/fault     FETCH|EXEC|MEMRD / HALT / FAULT state indicators
//   fault_pc              address of the instruction that faulted
//   dbg_sel/dbg_data      combinational register peek, 0 for unused indices
//   retired_cnt           only with MICRO_CORE_PERF_EN defined: saturating count
//                         of instructions completed without fault
//
// Optional feature macro: MICRO_CORE_PERF_EN
module micro_core #(
   parameter int DATA_W    = 24,
   parameter int NREGS     = 8,
   parameter int MEM_DEPTH = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   input  logic              start,
   output logic              busy,
   output logic              halted,
   output logic              fault,
   output logic [15:0]       fault_pc,
   input  logic [7:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
`ifdef MICRO_CORE_PERF_EN
   ,
   output logic [31:0]       retired_cnt
`endif
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [8:0]        NREGS_L = 9'(NREGS);
   localparam logic [16:0]       DEPTH_L = 17'(MEM_DEPTH);
   localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(MEM_DEPTH);

   localparam logic [7:0] OP_HALT      = 8'h00;
   localparam logic [7:0] OP_RESETREGS = 8'h01;
   localparam logic [7:0] OP_MOVNUMREG = 8'h02;
   localparam logic [7:0] OP_MOVREGREG = 8'h03;
   localparam logic [7:0] OP_MOVMEMREG = 8'h04;
   localparam logic [7:0] OP_MOVREGMEM = 8'h05;
   localparam logic [7:0] OP_ADD       = 8'h06;
   localparam logic [7:0] OP_SUB       = 8'h07;
   localparam logic [7:0] OP_INC       = 8'h08;
   localparam logic [7:0] OP_DEC       = 8'h09;
   localparam logic [7:0] OP_AND       = 8'h0A;
   localparam logic [7:0] OP_OR        = 8'h0B;
   localparam logic [7:0] OP_XOR       = 8'h0C;
   localparam logic [7:0] OP_CMP       = 8'h0D;
   localparam logic [7:0] OP_JMP       = 8'h0E;
   localparam logic [7:0] OP_JE        = 8'h0F;
   localparam logic [7:0] OP_JNE       = 8'h10;

   typedef enum logic [2:0] {
      ST_LOAD, ST_FETCH, ST_EXEC, ST_MEMRD, ST_HALT, ST_FAULT
   } state_t;

   state_t            state_reg, state_next;
   // 17 bits so that an address equal to MEM_DEPTH (up to 65536) is representable
   logic [16:0]       pc_reg, pc_next;
   logic [16:0]       load_ptr_reg, load_ptr_next;
   logic              cmp_reg, cmp_next;
   logic [15:0]       fault_pc_reg, fault_pc_next;
   logic [RW-1:0]     dst_reg, dst_next;

   logic [DATA_W-1:0] rf_reg [NREGS];
   logic [NREGS-1:0]  reg_we;
   logic              reg_wr_en;
   logic [RW-1:0]     reg_wr_idx;
   logic [DATA_W-1:0] reg_wr_data;
   logic              regs_clear;

   logic [DATA_W-1:0] mem_ram [MEM_DEPTH];
   logic [DATA_W-1:0] mem_q_reg;
   logic              mem_we, mem_wr;
   logic [AW-1:0]     mem_waddr, mem_raddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              exec_fault;
   logic              restart_ok;

   // Decode of the word read in FETCH; mem_q_reg holds it throughout EXEC.
   logic [7:0]        op, fa, fb;
   logic              a_ok, b_ok;
   logic [DATA_W-1:0] ra, rb;
   logic              ra_in_mem, rb_in_mem;
   logic [16:0]       jmp_target;

   assign op         = mem_q_reg[23:16];
   assign fa         = mem_q_reg[15:8];
   assign fb         = mem_q_reg[7:0];
   assign a_ok       = {1'b0, fa} < NREGS_L;
   assign b_ok       = {1'b0, fb} < NREGS_L;
   assign ra         = a_ok ? rf_reg[fa[RW-1:0]] : '0;
   assign rb         = b_ok ? rf_reg[fb[RW-1:0]] : '0;
   assign ra_in_mem  = ra < DEPTH_D;
   assign rb_in_mem  = rb < DEPTH_D;
   assign jmp_target = {1'b0, mem_q_reg[15:0]};

   assign restart_ok = (state_reg == ST_LOAD) || (state_reg == ST_HALT) ||
                       (state_reg == ST_FAULT);

   assign load_ready = (state_reg == ST_LOAD) && (load_ptr_reg < DEPTH_L);
   assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) ||
                       (state_reg == ST_MEMRD);
   assign halted     = (state_reg == ST_HALT);
   assign fault      = (state_reg == ST_FAULT);
   assign fault_pc   = fault_pc_reg;
   assign dbg_data   = ({1'b0, dbg_sel} < NREGS_L) ? rf_reg[dbg_sel[RW-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_LOAD;
         pc_reg       <= '0;
         load_ptr_reg <= '0;
         cmp_reg      <= 1'b0;
         fault_pc_reg <= '0;
         dst_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         load_ptr_reg <= load_ptr_next;
         cmp_reg      <= cmp_next;
         fault_pc_reg <= fault_pc_next;
         dst_reg      <= dst_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      load_ptr_next = load_ptr_reg;
      cmp_next      = cmp_reg;
      fault_pc_next = fault_pc_reg;
      dst_next      = dst_reg;
      reg_wr_en     = 1'b0;
      reg_wr_idx    = fa[RW-1:0];
      reg_wr_data   = '0;
      regs_clear    = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = load_ptr_reg[AW-1:0];
      mem_wdata     = load_data;
      mem_raddr     = pc_reg[AW-1:0];
      exec_fault    = 1'b0;

      case (state_reg)
         ST_LOAD, ST_HALT, ST_FAULT: begin
            // start wins over a load beat in the same cycle; the beat is lost
            if (start) begin
               pc_next    = '0;
               cmp_next   = 1'b0;
               state_next = ST_FETCH;
            end else if (load_valid && load_ready) begin
               mem_we        = 1'b1;
               load_ptr_next = load_ptr_reg + 17'd1;
            end
         end

         ST_FETCH: begin
            if (pc_reg >= DEPTH_L) begin
               state_next    = ST_FAULT;
               fault_pc_next = pc_reg[15:0];
            end else begin
               pc_next    = pc_reg + 17'd1;
               state_next = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_next = ST_FETCH;
            case (op)
               OP_HALT:      state_next = ST_HALT;
               OP_RESETREGS: regs_clear = 1'b1;
               OP_MOVNUMREG: begin
                  exec_fault  = !a_ok;
                  reg_wr_en   = 1'b1;
                  reg_wr_data = DATA_W'(fb);
               end
               OP_MOVREGREG: begin
                  exec_fault  = !(a_ok && b_ok);
                  reg_wr_en   = 1'b1;
                  reg_wr_data = rb;
               end
               OP_MOVMEMREG: begin
                  exec_fault = !(a_ok && b_ok) || !ra_in_mem;
                  mem_we     = 1'b1;
                  mem_waddr  = ra[AW-1:0];
                  mem_wdata  = rb;
               end
               OP_MOVREGMEM: begin
                  // data word is read at the end of EXEC and written back in MEMRD
                  exec_fault = !(a_ok && b_ok) || !rb_in_mem;
                  mem_raddr  = rb[AW-1:0];
                  dst_next   = fa[RW-1:0];
                  state_next = ST_MEMRD;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  exec_fault = !(a_ok && b_ok);
                  reg_wr_en  = 1'b1;
                  case (op)
                     OP_ADD:  reg_wr_data = ra + rb;
                     OP_SUB:  reg_wr_data = ra - rb;
                     OP_AND:  reg_wr_data = ra & rb;
                     OP_OR:   reg_wr_data = ra | rb;
                     default: reg_wr_data = ra ^ rb;
                  endcase
               end
               OP_INC, OP_DEC: begin
                  exec_fault  = !a_ok;
                  reg_wr_en   = 1'b1;
                  reg_wr_data = (op == OP_INC) ? ra + 1'b1 : ra - 1'b1;
               end
               OP_CMP: begin
                  exec_fault = !(a_ok && b_ok);
                  cmp_next   = (ra == rb);
               end
               OP_JMP, OP_JE, OP_JNE: begin
                  if ((op == OP_JMP) || ((op == OP_JE) && cmp_reg) ||
                      ((op == OP_JNE) && !cmp_reg)) begin
                     if (jmp_target >= DEPTH_L) exec_fault = 1'b1;
                     else                       pc_next    = jmp_target;
                  end
               end
               default: exec_fault = 1'b1;
            endcase

            // A faulting instruction must leave no trace in architectural state.
            if (exec_fault) begin
               state_next    = ST_FAULT;
               fault_pc_next = pc_reg[15:0] - 16'd1;
               pc_next       = pc_reg;
               cmp_next      = cmp_reg;
               dst_next      = dst_reg;
               reg_wr_en     = 1'b0;
               regs_clear    = 1'b0;
               mem_we        = 1'b0;
            end
         end

         ST_MEMRD: begin
            reg_wr_en   = 1'b1;
            reg_wr_idx  = dst_reg;
            reg_wr_data = mem_q_reg;
            state_next  = ST_FETCH;
         end

         default: state_next = ST_LOAD;
      endcase
   end

   // Register file: per-entry write enables, whole-file clear for RESETREGS.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg_we
         assign reg_we[gi] = regs_clear || (reg_wr_en && (reg_wr_idx == RW'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (reg_we[i]) rf_reg[i] <= regs_clear ? '0 : reg_wr_data;
         end
      end
   end

   // Memory survives reset. A write pending on a reset edge is suppressed so a
   // reset in mid-instruction (or a beat offered while reset is held) is lost.
   assign mem_wr = mem_we && !rst;

   always_ff @(posedge clk) begin
      if (mem_wr) mem_ram[mem_waddr] <= mem_wdata;
      mem_q_reg <= mem_ram[mem_raddr];
   end

`ifdef MICRO_CORE_PERF_EN
   logic        retire;
   logic        perf_clear;
   logic [31:0] retired_cnt_reg;

   // An instruction retires when EXEC finishes without fault (MOVREGMEM only
   // once its MEMRD cycle completes).
   assign retire = ((state_reg == ST_EXEC) && (state_next != ST_FAULT) &&
                    (state_next != ST_MEMRD)) || (state_reg == ST_MEMRD);
   assign perf_clear = start && restart_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_cnt_reg <= '0;
      end else if (perf_clear) begin
         retired_cnt_reg <= '0;
      end else if (retire && (retired_cnt_reg != '1)) begin
         retired_cnt_reg <= retired_cnt_reg + 32'd1;
      end
   end

   assign retired_cnt = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_micro_core.sv
// Self-checking bench for micro_core: directed programs plus randomly
// generated programs, each checked against an instruction-level model.
module tb_micro_core;

   localparam int DATA_W = 24;
   localparam int NREGS  = 8;
   localparam int DEPTH  = 128;
   localparam int MASK   = 32'h00FF_FFFF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_ready;
   logic              start = 1'b0;
   logic              busy, halted, fault;
   logic [15:0]       fault_pc;
   logic [7:0]        dbg_sel = '0;
   logic [DATA_W-1:0] dbg_data;
`ifdef MICRO_CORE_PERF_EN
   logic [31:0]       retired_cnt;
`endif

   always #5 clk = ~clk;

   micro_core #(.DATA_W(DATA_W), .NREGS(NREGS), .MEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .start      (start),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault),
      .fault_pc   (fault_pc),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
`ifdef MICRO_CORE_PERF_EN
      ,
      .retired_cnt(retired_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // reference state
   int m_mem [DEPTH];     // memory image as of the last completed run
   int t_mem [DEPTH];     // working copy used by the model
   int t_regs [NREGS];
   int prog [64];
   int exp_halt, exp_fault, exp_fpc, exp_cycles, exp_retired;
   bit nonterm;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction-level model: runs t_mem from address 0 with cleared registers.
   task automatic model_run();
      int pc, flag, steps, w, op, a, b, ra, rb, nxt;
      bit done, ok, taken;
      for (int i = 0; i < NREGS; i++) t_regs[i] = 0;
      pc = 0; flag = 0; steps = 0; done = 0; nonterm = 0;
      exp_cycles = 1; exp_halt = 0; exp_fault = 0; exp_fpc = 0; exp_retired = 0;
      while (!done) begin
         if (steps > 400) begin
            nonterm = 1;
            done = 1;
         end else if (pc >= DEPTH) begin
            exp_fault = 1; exp_fpc = pc; exp_cycles += 1; done = 1;
         end else begin
            w  = t_mem[pc];
            op = (w >> 16) & 255;
            a  = (w >> 8) & 255;
            b  = w & 255;
            ra = (a < NREGS) ? t_regs[a] : 0;
            rb = (b < NREGS) ? t_regs[b] : 0;
            exp_cycles += 2;
            steps++;
            ok  = 1;
            nxt = pc + 1;
            case (op)
               0: begin exp_halt = 1; done = 1; end
               1: for (int i = 0; i < NREGS; i++) t_regs[i] = 0;
               2: if (a >= NREGS) ok = 0; else t_regs[a] = b;
               3: if (a >= NREGS || b >= NREGS) ok = 0; else t_regs[a] = rb;
               4: if (a >= NREGS || b >= NREGS || ra >= DEPTH) ok = 0; else t_mem[ra] = rb;
               5: if (a >= NREGS || b >= NREGS || rb >= DEPTH) ok = 0;
                  else begin t_regs[a] = t_mem[rb]; exp_cycles += 1; end
               6, 7, 10, 11, 12, 13: begin
                  if (a >= NREGS || b >= NREGS) ok = 0;
                  else case (op)
                     6:  t_regs[a] = (ra + rb) & MASK;
                     7:  t_regs[a] = (ra - rb) & MASK;
                     10: t_regs[a] = ra & rb;
                     11: t_regs[a] = ra | rb;
                     12: t_regs[a] = ra ^ rb;
                     default: flag = (ra == rb) ? 1 : 0;
                  endcase
               end
               8: if (a >= NREGS) ok = 0; else t_regs[a] = (ra + 1) & MASK;
               9: if (a >= NREGS) ok = 0; else t_regs[a] = (ra - 1) & MASK;
               14, 15, 16: begin
                  taken = (op == 14) || (op == 15 && flag != 0) || (op == 16 && flag == 0);
                  if (taken) begin
                     if ((w & 65535) >= DEPTH) ok = 0;
                     else nxt = w & 65535;
                  end
               end
               default: ok = 0;
            endcase
            if (!ok) begin
               exp_fault = 1; exp_fpc = pc; done = 1;
            end else begin
               exp_retired++;
            end
            pc = nxt;
         end
      end
   endtask

   task automatic do_reset();
      load_valid = 1'b0;
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i][DATA_W-1:0];
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
   endtask

   task automatic start_and_wait(input string name, output int cyc);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!(halted || fault) && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_value({name, "_done"}, 32'(halted | fault), 1);
   endtask

   task automatic read_reg(input int idx, output logic [DATA_W-1:0] val);
      dbg_sel = 8'(idx);
      #1;
      val = dbg_data;
   endtask

   task automatic compare_result(input string name, input int cyc);
      logic [DATA_W-1:0] v;
      $display("run %s cycles=%0d halted=%0b fault=%0b fault_pc=%0d", name, cyc, halted, fault, fault_pc);
      check_value({name, "_halted"}, 32'(halted), exp_halt);
      check_value({name, "_fault"}, 32'(fault), exp_fault);
      check_value({name, "_busy"}, 32'(busy), 0);
      check_value({name, "_cycles"}, cyc, exp_cycles);
      if (exp_fault != 0) check_value({name, "_fault_pc"}, 32'(fault_pc), exp_fpc);
      for (int i = 0; i < NREGS; i++) begin
         read_reg(i, v);
         check_value($sformatf("%s_r%0d", name, i), 32'(v), t_regs[i]);
      end
      read_reg($urandom_range(NREGS, 255), v);
      check_value({name, "_dbg_oob"}, 32'(v), 0);
`ifdef MICRO_CORE_PERF_EN
      check_value({name, "_retired"}, retired_cnt, exp_retired);
`endif
   endtask

   // Reset, load prog[0..n-1], run, and compare with the model.
   task automatic run_program(input string name, input int n, output int cyc);
      t_mem = m_mem;
      for (int i = 0; i < n; i++) t_mem[i] = prog[i];
      model_run();
      do_reset();
      load_words(n);
      start_and_wait(name, cyc);
      compare_result(name, cyc);
      m_mem = t_mem;
   endtask

   function automatic int rnd_reg();
      return ($urandom_range(0, 11) == 0) ? int'($urandom_range(NREGS, 255)) : int'($urandom_range(0, NREGS - 1));
   endfunction

   task automatic gen_program(output int n);
      int op_tab [24] = '{1, 2, 2, 2, 2, 3, 4, 4, 5, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 15, 16, 16};
      int op, r;
      n = $urandom_range(4, 20);
      for (int i = 0; i < n - 1; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3)       op = $urandom_range(17, 255);
         else if (r < 4)  op = 0;
         else             op = op_tab[$urandom_range(0, 23)];
         if (op >= 14 && op <= 16) begin
            if ($urandom_range(0, 7) == 0) prog[i] = (op << 16) | int'($urandom_range(DEPTH, 65535));
            else prog[i] = (op << 16) | int'($urandom_range(i + 1, n - 1));
         end else if (op == 2) begin
            prog[i] = (op << 16) | (rnd_reg() << 8) | int'($urandom_range(0, 150));
         end else begin
            prog[i] = (op << 16) | (rnd_reg() << 8) | rnd_reg();
         end
      end
      prog[n - 1] = 0;
   endtask

   initial begin
      int cyc, acc, n, tries;
      logic [DATA_W-1:0] v;

      // reset state
      #2;
      check_value("rst_busy", 32'(busy), 0);
      check_value("rst_halted", 32'(halted), 0);
      check_value("rst_fault", 32'(fault), 0);
      check_value("rst_load_ready", 32'(load_ready), 1);
      check_value("rst_fault_pc", 32'(fault_pc), 0);
      for (int i = 0; i < NREGS; i++) begin
         read_reg(i, v);
         check_value($sformatf("rst_r%0d", i), 32'(v), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // fill: 130 beats offered, only 128 land, no wrap onto address 0
      for (int i = 0; i < 130; i++) prog[i % 64] = 0;
      acc = 0;
      for (int i = 0; i < 130; i++) begin
         load_valid = 1'b1;
         load_data  = (i >= DEPTH) ? 24'h020109 : 24'h000000;
         acc += int'(load_ready);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      check_value("fill_accepted", acc, DEPTH);
      check_value("fill_load_ready", 32'(load_ready), 0);
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      t_mem = m_mem;
      model_run();
      start_and_wait("fill", cyc);
      compare_result("fill", cyc);
      read_reg(1, v);
      check_value("fill_no_wrap_r1", 32'(v), 0);

      // add program: halted after 9 cycles, R1 = 8
      prog[0] = 'h020105; prog[1] = 'h020203; prog[2] = 'h060102; prog[3] = 'h000000;
      run_program("add", 4, cyc);
      check_value("add_cycles9", cyc, 9);
      read_reg(1, v);
      check_value("add_r1", 32'(v), 8);

      // DEC of zero wraps to all-ones
      prog[0] = 'h020100; prog[1] = 'h090100; prog[2] = 'h000000;
      run_program("dec0", 3, cyc);
      read_reg(1, v);
      check_value("dec0_r1", 32'(v), 32'hFFFFFF);
      check_value("dec0_nofault", 32'(fault), 0);

      // JE taken over the R1 overwrite
      prog[0] = 'h020105; prog[1] = 'h020205; prog[2] = 'h0D0102;
      prog[3] = 'h0F0005; prog[4] = 'h020101; prog[5] = 'h000000;
      run_program("je", 6, cyc);
      read_reg(1, v);
      check_value("je_r1", 32'(v), 5);
      check_value("je_halted", 32'(halted), 1);

      // MOVREGMEM from an out-of-range address faults at 4
      prog[0] = 'h020209; prog[1] = 'h020107; prog[2] = 'h040201;
      prog[3] = 'h0201C8; prog[4] = 'h050301;
      run_program("memflt", 5, cyc);
      check_value("memflt_fault", 32'(fault), 1);
      check_value("memflt_pc", 32'(fault_pc), 4);
      read_reg(3, v);
      check_value("memflt_r3", 32'(v), 0);

      // reset during EXEC of ADD, then rerun from preserved memory
      prog[0] = 'h020105; prog[1] = 'h020203; prog[2] = 'h060102; prog[3] = 'h000000;
      do_reset();
      load_words(4);
      for (int i = 0; i < 4; i++) m_mem[i] = prog[i];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      read_reg(1, v);
      check_value("midrst_pre_r1", 32'(v), 5);
      check_value("midrst_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      read_reg(1, v);
      check_value("midrst_r1", 32'(v), 0);
      read_reg(2, v);
      check_value("midrst_r2", 32'(v), 0);
      check_value("midrst_busy", 32'(busy), 0);
      check_value("midrst_load_ready", 32'(load_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      t_mem = m_mem;
      model_run();
      start_and_wait("midrst_rerun", cyc);
      compare_result("midrst_rerun", cyc);
      read_reg(1, v);
      check_value("midrst_rerun_r1", 32'(v), 8);

      // random programs
      for (int t = 0; t < 40; t++) begin
         tries = 0;
         do begin
            gen_program(n);
            t_mem = m_mem;
            for (int i = 0; i < n; i++) t_mem[i] = prog[i];
            model_run();
            tries++;
         end while (nonterm && tries < 20);
         if (!nonterm) run_program($sformatf("rnd%0d", t), n, cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
